// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and error-rule definitions shared by the ALU initiator
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT1 = 4'h6;
    localparam logic [3:0] OP_NOT2 = 4'h7;
    localparam logic [3:0] OP_SQ1  = 4'h8;
    localparam logic [3:0] OP_SQ2  = 4'h9;
    localparam logic [3:0] OP_LT   = 4'hA;
    localparam logic [3:0] OP_EQ   = 4'hB;
    localparam logic [3:0] OP_GT   = 4'hC;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Divide by zero and anything above OP_GT (including NOP) is reported as an error.
    function automatic logic op_is_err(input logic [3:0] op, input logic [7:0] in2);
        return ((op == OP_DIV) && (in2 == 8'h00)) || (op > OP_GT);
    endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// rtl/alu_sat_counter.sv - saturating up-counter with synchronous clear
module alu_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_cmd_initiator.sv
// rtl/alu_cmd_initiator.sv - command sequencer driving a combinational ALU and returning captured results
module alu_cmd_initiator
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_chain,
    output logic [3:0]       alu_sel,
    output logic [7:0]       alu_in1,
    output logic [7:0]       alu_in2,
    input  logic [15:0]      alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_err,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  settle_cnt;
    logic [15:0] acc;
    logic        capture;
    logic        cap_err;

    // The error decision uses the registered select/operand actually presented to the ALU.
    assign capture = (state == ST_DRIVE) && (settle_cnt == 4'd0);
    assign cap_err = op_is_err(alu_sel, alu_in2);

    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            alu_sel    <= OP_NOP;
            alu_in1    <= 8'h00;
            alu_in2    <= 8'h00;
            res_data   <= 16'h0000;
            res_err    <= 1'b0;
            res_zero   <= 1'b0;
            acc        <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state      <= ST_DRIVE;
                        alu_sel    <= cmd_op;
                        alu_in1    <= cmd_chain ? acc[7:0] : cmd_a;
                        alu_in2    <= cmd_b;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        res_data <= alu_out;
                        res_err  <= cap_err;
                        res_zero <= (alu_out == 16'h0000);
                        if (!cap_err) begin
                            acc <= alu_out;
                        end
                        // Park the ALU on NOP so it sits at a known zero output between commands.
                        alu_sel  <= OP_NOP;
                        alu_in1  <= 8'h00;
                        alu_in2  <= 8'h00;
                        state    <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    alu_sat_counter #(
        .WIDTH(CNT_W)
    ) u_op_count (
        .clk  (clk),
        .clr  (rst),
        .inc  (capture),
        .count(op_count)
    );

    alu_sat_counter #(
        .WIDTH(CNT_W)
    ) u_err_count (
        .clk  (clk),
        .clr  (rst),
        .inc  (capture && cap_err),
        .count(err_count)
    );

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// tb/tb_alu_cmd_initiator.sv - directed vector bench for alu_cmd_initiator
module tb_alu_cmd_initiator;

    localparam int SETTLE = 2;
    localparam int CW     = 8;
    localparam int NV     = 21;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        chain;
        logic [7:0]  in1;
        logic [15:0] data;
        logic        err;
        logic        zero;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic          cmd_chain;
    logic [3:0]    alu_sel;
    logic [7:0]    alu_in1;
    logic [7:0]    alu_in2;
    logic [15:0]   alu_out;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic          res_err;
    logic          res_zero;
    logic [CW-1:0] op_count;
    logic [CW-1:0] err_count;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_cmd_initiator #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_chain(cmd_chain),
        .alu_sel  (alu_sel),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .res_zero (res_zero),
        .op_count (op_count),
        .err_count(err_count),
        .busy     (busy)
    );

    // Behavioural combinational ALU.
    always_comb begin
        alu_out = 16'h0000;
        case (alu_sel)
            4'h0: alu_out = {8'h00, alu_in1} + {8'h00, alu_in2};
            4'h1: alu_out = {8'h00, alu_in1} - {8'h00, alu_in2};
            4'h2: alu_out = {8'h00, alu_in1} * {8'h00, alu_in2};
            4'h3: alu_out = (alu_in2 == 8'h00) ? 16'h0000 : ({8'h00, alu_in1} / {8'h00, alu_in2});
            4'h4: alu_out = {8'h00, alu_in1 & alu_in2};
            4'h5: alu_out = {8'h00, alu_in1 | alu_in2};
            4'h6: alu_out = {8'h00, ~alu_in1};
            4'h7: alu_out = {8'h00, ~alu_in2};
            4'h8: alu_out = {8'h00, alu_in1} * {8'h00, alu_in1};
            4'h9: alu_out = {8'h00, alu_in2} * {8'h00, alu_in2};
            4'hA: alu_out = {15'h0000, alu_in1 < alu_in2};
            4'hB: alu_out = {15'h0000, alu_in1 == alu_in2};
            4'hC: alu_out = {15'h0000, alu_in1 > alu_in2};
            default: alu_out = 16'h0000;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, return the result and the accept-to-res_valid latency in cycles.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic chain, output logic [15:0] d, output int lat);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        d = res_data;
        if (res_ready) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int          lat;
        int          exp_errs;
        int          seen;

        vecs[0]  = '{4'h0, 8'h05, 8'h03, 1'b0, 8'h05, 16'h0008, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 8'h0F, 8'hFF, 1'b0, 8'h0F, 16'h0EF1, 1'b0, 1'b0};
        vecs[2]  = '{4'h0, 8'hAA, 8'h01, 1'b1, 8'hF1, 16'h00F2, 1'b0, 1'b0};
        vecs[3]  = '{4'h3, 8'h09, 8'h00, 1'b0, 8'h09, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{4'hE, 8'h12, 8'h34, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{4'h1, 8'h00, 8'h02, 1'b1, 8'hF2, 16'h00F0, 1'b0, 1'b0};
        vecs[6]  = '{4'h1, 8'h03, 8'h05, 1'b0, 8'h03, 16'hFFFE, 1'b0, 1'b0};
        vecs[7]  = '{4'h3, 8'h64, 8'h07, 1'b0, 8'h64, 16'h000E, 1'b0, 1'b0};
        vecs[8]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 8'hF0, 16'h0030, 1'b0, 1'b0};
        vecs[9]  = '{4'h5, 8'hF0, 8'h0F, 1'b0, 8'hF0, 16'h00FF, 1'b0, 1'b0};
        vecs[10] = '{4'h6, 8'h5A, 8'h00, 1'b0, 8'h5A, 16'h00A5, 1'b0, 1'b0};
        vecs[11] = '{4'h9, 8'h00, 8'h10, 1'b0, 8'h00, 16'h0100, 1'b0, 1'b0};
        vecs[12] = '{4'hA, 8'h03, 8'h05, 1'b0, 8'h03, 16'h0001, 1'b0, 1'b0};
        vecs[13] = '{4'hB, 8'h07, 8'h07, 1'b0, 8'h07, 16'h0001, 1'b0, 1'b0};
        vecs[14] = '{4'hC, 8'h02, 8'h09, 1'b0, 8'h02, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{4'h0, 8'h40, 8'h02, 1'b0, 8'h40, 16'h0042, 1'b0, 1'b0};
        vecs[16] = '{4'hD, 8'h11, 8'h22, 1'b0, 8'h11, 16'h0000, 1'b1, 1'b1};
        vecs[17] = '{4'h0, 8'h99, 8'h01, 1'b1, 8'h42, 16'h0043, 1'b0, 1'b0};
        vecs[18] = '{4'hF, 8'h01, 8'h01, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b1};
        vecs[19] = '{4'h7, 8'h00, 8'hF0, 1'b0, 8'h00, 16'h000F, 1'b0, 1'b0};
        vecs[20] = '{4'h8, 8'hFF, 8'h00, 1'b0, 8'hFF, 16'hFE01, 1'b0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_chain = 1'b0; res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_sel", alu_sel, 4'hF);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_in2", alu_in2, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_res_data", res_data, 0);

        exp_errs = 0;
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
            cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
            cmd_chain = vecs[i].chain; cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_alu_sel", i), alu_sel, vecs[i].op);
            chk($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].in1);
            chk($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].b);
            lat = 0;
            while (!res_valid && lat < 20) begin
                if (lat > 0) chk($sformatf("v%0d_sel_hold", i), alu_sel, vecs[i].op);
                tick();
                lat++;
            end
            if (vecs[i].err) exp_errs++;
            chk($sformatf("v%0d_latency", i), lat, SETTLE);
            chk($sformatf("v%0d_res_data", i), res_data, vecs[i].data);
            chk($sformatf("v%0d_res_err", i), res_err, vecs[i].err);
            chk($sformatf("v%0d_res_zero", i), res_zero, vecs[i].zero);
            chk($sformatf("v%0d_quiet_sel", i), alu_sel, 4'hF);
            chk($sformatf("v%0d_op_count", i), op_count, i + 1);
            chk($sformatf("v%0d_err_count", i), err_count, exp_errs);
            tick();
            chk($sformatf("v%0d_idle", i), busy, 0);
            chk($sformatf("v%0d_data_hold", i), res_data, vecs[i].data);
        end

        // Backpressure: result must sit still and no new command may be taken.
        res_ready = 1'b0;
        run_cmd(4'h0, 8'h01, 8'h01, 1'b0, d, lat);
        chk("bp_latency", lat, SETTLE);
        cmd_op = 4'h1; cmd_a = 8'h09; cmd_b = 8'h04; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_res_data", res_data, 16'h0002);
            chk("bp_alu_sel", alu_sel, 4'hF);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_busy", busy, 0);
        chk("bp_release_ready", cmd_ready, 1);
        chk("bp_release_data", res_data, 16'h0002);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        chk("bp_next_sel", alu_sel, 4'h1);
        chk("bp_next_in1", alu_in1, 8'h09);
        chk("bp_next_in2", alu_in2, 8'h04);
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_next_latency", lat, SETTLE);
        chk("bp_next_data", res_data, 16'h0005);
        tick();

        // Abort in DRIVE: reset wins and nothing is captured.
        cmd_op = 4'h0; cmd_a = 8'h10; cmd_b = 8'h20; cmd_chain = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("ab_in_drive", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_cmd_ready", cmd_ready, 1);
        chk("ab_res_valid", res_valid, 0);
        chk("ab_alu_sel", alu_sel, 4'hF);
        chk("ab_alu_in1", alu_in1, 0);
        chk("ab_alu_in2", alu_in2, 0);
        chk("ab_op_count", op_count, 0);
        chk("ab_err_count", err_count, 0);
        chk("ab_res_data", res_data, 0);
        chk("ab_res_err", res_err, 0);
        chk("ab_res_zero", res_zero, 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("ab_no_res_valid", seen, 0);
        run_cmd(4'h0, 8'h77, 8'h05, 1'b1, d, lat);
        chk("ab_chain_acc_cleared", d, 16'h0005);

        // Saturation: 300 divide-by-zero captures push both counters to the top.
        for (int j = 0; j < 300; j++) begin
            run_cmd(4'h3, 8'(j), 8'h00, 1'b0, d, lat);
            if (j == 198) begin
                chk("sat_op_mid", op_count, 200);
                chk("sat_err_mid", err_count, 199);
            end
        end
        chk("sat_op_count", op_count, 255);
        chk("sat_err_count", err_count, 255);
        chk("sat_res_err", res_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_initiator.md
# alu_cmd_initiator

Initiator-side sequencer for the 4-bit-opcode combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU select and operand lines with registered, stable values. After a programmable settle window it captures the 16-bit ALU result and returns it over a second valid/ready handshake. It also keeps a result accumulator for chained operations, flags errors, and maintains saturating operation/error counters. It sits between the host/command front-end and the ALU instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles ALU inputs are held before capture; legal range 1..15.
- `CNT_W`, default 8: width of `op_count` and `err_count`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: initiator can accept a command.
- `cmd_op` in 4: ALU opcode (0x0..0xC defined).
- `cmd_a` in 8: operand 1; ignored when `cmd_chain`=1.
- `cmd_b` in 8: operand 2.
- `cmd_chain` in 1: use `acc[7:0]` as operand 1.
- `alu_sel` out 4: to ALU select.
- `alu_in1` out 8: to ALU operand 1.
- `alu_in2` out 8: to ALU operand 2.
- `alu_out` in 16: ALU result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 16: captured result.
- `res_err` out 1: divide-by-zero or undefined opcode.
- `res_zero` out 1: `res_data` == 0.
- `op_count` out CNT_W: captures performed, saturating.
- `err_count` out CNT_W: captures with `res_err`, saturating.
- `busy` out 1: state != IDLE.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - DRIVE: ALU inputs held, settle counter runs.
  - RESP: `res_valid`=1.
- IDLE→DRIVE on `cmd_valid & cmd_ready`. At that edge:
  - `alu_sel` ← `cmd_op`.
  - `alu_in1` ← `cmd_chain ? acc[7:0] : cmd_a`.
  - `alu_in2` ← `cmd_b`.
  - Settle counter ← SETTLE_CYCLES-1.
- DRIVE: counter decrements each cycle. At the edge where the counter is 0:
  - `res_data` ← `alu_out`.
  - `res_err`, `res_zero` computed.
  - Counters update.
  - `alu_sel` ← 0xF (quiescent, ALU outputs 0); `alu_in1`, `alu_in2` ← 0.
  - Go to RESP.
- Error rule: `res_err`=1 when opcode is 0x3 with `alu_in2`=0, or opcode ≥ 0xD. `res_data` is still the raw `alu_out` (0 in both cases).
- Accumulator: `acc` (16 bit) ← `alu_out` on capture when `res_err`=0; it holds on error.
- RESP→IDLE on `res_valid & res_ready`.
- `res_data`, `res_err`, `res_zero` stay stable in RESP until that handshake, and hold their last value afterward.
- `cmd_valid` is ignored in DRIVE and RESP.
- Width rules:
  - `alu_out` is passed through unmodified (no sign interpretation).
  - `op_count` and `err_count` saturate at 2^CNT_W-1; no wrap.
- Reset values:
  - State IDLE, so `cmd_ready`=1 and `busy`=0.
  - `alu_sel`=0xF; `alu_in1`, `alu_in2` = 0.
  - `res_valid`=0; `res_data`=0; `res_err`=0; `res_zero`=0.
  - `acc`=0; `op_count`=0; `err_count`=0.
- Reset during DRIVE or RESP aborts the operation: no capture, no `res_valid`, all registers take reset values on that edge.

## Timing
- Command accepted at edge k. ALU inputs are valid from after edge k through edge k+SETTLE_CYCLES (ALU path gets SETTLE_CYCLES full cycles).
- Capture at edge k+SETTLE_CYCLES. `res_valid`=1 from after that edge.
- Result handshake at edge m gives IDLE after m; the earliest next accept is edge m+1.
- Minimum command period: SETTLE_CYCLES+2 cycles with `res_ready` tied high.
- `cmd_ready`, `res_valid` and `busy` are decoded from registered state only; there is no combinational path from `cmd_valid` or `res_ready`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: OP_ADD=0x0, OP_SUB=0x1, OP_MUL=0x2, OP_DIV=0x3, OP_AND=0x4, OP_OR=0x5, OP_NOT1=0x6, OP_NOT2=0x7, OP_SQ1=0x8, OP_SQ2=0x9, OP_LT=0xA, OP_EQ=0xB, OP_GT=0xC, OP_NOP=0xF.
  - State encoding (IDLE/DRIVE/RESP).
- One sub-module, `alu_sat_counter` (parameter width, synchronous clear, increment-enable, saturating), instantiated twice for `op_count` and `err_count`.

## Test plan
All scenarios use SETTLE_CYCLES=2 and a behavioural ALU model.
1. Reset: `rst`=1 for 2 cycles, then 0 → `cmd_ready`=1, `busy`=0, `res_valid`=0, `alu_sel`=0xF, `alu_in1`=`alu_in2`=0, counters 0.
2. ADD, `cmd_a`=0x05, `cmd_b`=0x03, `res_ready`=1 → `alu_sel`=0x0 for 2 cycles, `res_valid` high 2 cycles after accept, `res_data`=0x0008, `res_err`=0, `res_zero`=0, `op_count`=1.
3. Chaining: MUL 0x0F×0xFF → `res_data`=0x0EF1. Then ADD with `cmd_chain`=1, `cmd_b`=0x01, `cmd_a`=0xAA → `alu_in1`=0xF1, `res_data`=0x00F2.
4. Errors: DIV, `cmd_a`=0x09, `cmd_b`=0x00 → `res_data`=0, `res_err`=1, `res_zero`=1, `err_count`=1, `acc` unchanged. Then opcode 0xE → `err_count`=2.
5. Backpressure: `res_ready`=0 for 10 cycles with `cmd_valid`=1 → `res_data` stable, `cmd_ready`=0, no second accept. Raise `res_ready` → IDLE next cycle, accept on the following edge.
6. Abort: `rst` pulsed for 1 cycle in DRIVE → reset values next cycle, `res_valid` never asserts, `op_count`=0. Saturation: 300 captures with CNT_W=8 → `op_count`=255.
